register_window_file: RTL and testbench

//  SPARC V8 windowed integer register file with two read ports, one write port and CWP/WIM control.

---
 rtl/register_window_file_pkg.sv | 30 +++
 rtl/register_window_file_window_index_map.sv | 43 ++++
 rtl/register_window_file.sv | 143 ++++++++++++++
 tb/tb_register_window_file.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_window_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_window_file_pkg
//  Description : Shared constants and sizing helpers for the windowed
//                register file (globals count, registers per window,
//                physical register count, CWP and physical index widths).
//  Revision    : 1.0  initial release
// ============================================================================
package register_window_file_pkg;

    localparam int NGLOBALS     = 8;
    localparam int REGS_PER_WIN = 16;

    // Physical register count: globals plus 16 unique registers per window.
    // Each window only owns its locals and ins; its outs are the next
    // window's ins.
    function automatic int nphys(input int nwindows);
        return NGLOBALS + REGS_PER_WIN * nwindows;
    endfunction

    function automatic int cwp_width(input int nwindows);
        return (nwindows > 1) ? $clog2(nwindows) : 1;
    endfunction

    function automatic int phys_width(input int nwindows);
        return $clog2(nphys(nwindows));
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_window_file_window_index_map.sv
`default_nettype none
// ============================================================================
//  Module      : window_index_map
//  Description : Combinational map from a logical register number and a
//                window pointer to a physical register index.
//                  lreg : logical register r0..r31
//                  cwp  : window pointer used for the translation
//                  preg : physical register index
//  Revision    : 1.0  initial release
// ============================================================================
module window_index_map
    import register_window_file_pkg::*;
#(
    parameter int NWINDOWS = 4
) (
    input  logic [4:0]                        lreg,
    input  logic [cwp_width(NWINDOWS)-1:0]    cwp,
    output logic [phys_width(NWINDOWS)-1:0]   preg
);

    localparam int c_CWP_W  = cwp_width(NWINDOWS);
    localparam int c_PHYS_W = phys_width(NWINDOWS);
    // Width of the windowed region offset: log2(16 * NWINDOWS).
    localparam int c_OFF_W  = c_CWP_W + 4;

    logic [4:0]         w_rel;
    logic [c_OFF_W-1:0] w_off;

    always_comb begin
        w_rel = lreg - 5'(NGLOBALS);
        // NWINDOWS is a power of two, so the modulo over the windowed
        // region is plain truncation to c_OFF_W bits. Window w starts at
        // offset 16*w, which makes its outs land on window w-1's ins.
        w_off = {cwp, 4'b0000} + c_OFF_W'(w_rel);
        if (lreg < 5'(NGLOBALS)) begin
            preg = c_PHYS_W'(lreg);
        end else begin
            preg = c_PHYS_W'(NGLOBALS) + c_PHYS_W'(w_off);
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_window_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_window_file
//  Description : SPARC V8 style windowed integer register file.
//                Two combinational read ports, one write port, CWP/WIM
//                control with SAVE/RESTORE and overflow/underflow traps.
//  Ports       : clk, reset_n (async active-low)
//                rs1/rs2 -> rs1_data/rs2_data  combinational reads
//                rd, wr_en, wr_data            edge-triggered write
//                save, restore                 window change requests
//                wr_wim/wim_in, wr_cwp/cwp_in  direct state loads
//                cwp, wim                      current window state
//                trap_ovf, trap_unf            registered 1-cycle traps
//  Revision    : 1.0  initial release
// ============================================================================
module register_window_file
    import register_window_file_pkg::*;
#(
    parameter int NWINDOWS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [4:0]                       rs1,
    input  logic [4:0]                       rs2,
    output logic [WIDTH-1:0]                 rs1_data,
    output logic [WIDTH-1:0]                 rs2_data,
    input  logic [4:0]                       rd,
    input  logic                             wr_en,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic                             save,
    input  logic                             restore,
    input  logic                             wr_wim,
    input  logic [NWINDOWS-1:0]              wim_in,
    input  logic                             wr_cwp,
    input  logic [cwp_width(NWINDOWS)-1:0]   cwp_in,
    output logic [cwp_width(NWINDOWS)-1:0]   cwp,
    output logic [NWINDOWS-1:0]              wim,
    output logic                             trap_ovf,
    output logic                             trap_unf
);

    localparam int c_NPHYS  = nphys(NWINDOWS);
    localparam int c_CWP_W  = cwp_width(NWINDOWS);
    localparam int c_PHYS_W = phys_width(NWINDOWS);

    logic [WIDTH-1:0]    r_regs [c_NPHYS];
    logic [c_CWP_W-1:0]  r_cwp;
    logic [NWINDOWS-1:0] r_wim;
    logic                r_trap_ovf;
    logic                r_trap_unf;

    logic [c_CWP_W-1:0]  w_cwp_dec;
    logic [c_CWP_W-1:0]  w_cwp_inc;
    logic                w_save_req;
    logic                w_restore_req;
    logic                w_ovf;
    logic                w_unf;
    logic [c_CWP_W-1:0]  w_cwp_next;
    logic [c_CWP_W-1:0]  w_rd_cwp;
    logic                w_wr_go;
    logic [c_PHYS_W-1:0] w_rs1_idx;
    logic [c_PHYS_W-1:0] w_rs2_idx;
    logic [c_PHYS_W-1:0] w_rd_idx;

    // Window arithmetic wraps naturally in c_CWP_W bits (NWINDOWS is 2^n).
    assign w_cwp_dec = r_cwp - c_CWP_W'(1);
    assign w_cwp_inc = r_cwp + c_CWP_W'(1);

    // wr_cwp overrides both requests; save together with restore cancels.
    assign w_save_req    = save    & ~restore & ~wr_cwp;
    assign w_restore_req = restore & ~save    & ~wr_cwp;

    // Trap checks use the WIM value held before this edge.
    assign w_ovf = w_save_req    & r_wim[w_cwp_dec];
    assign w_unf = w_restore_req & r_wim[w_cwp_inc];

    always_comb begin
        w_rd_cwp = r_cwp;
        if (w_save_req && !w_ovf) begin
            w_rd_cwp = w_cwp_dec;
        end else if (w_restore_req && !w_unf) begin
            w_rd_cwp = w_cwp_inc;
        end
        // A successful SAVE/RESTORE writes rd in the new window; a wr_cwp
        // load leaves the write in the old window.
        w_cwp_next = wr_cwp ? cwp_in : w_rd_cwp;
    end

    // Trapping requests also squash the write of the same cycle.
    assign w_wr_go = wr_en & (rd != 5'd0) & ~w_ovf & ~w_unf;

    window_index_map #(.NWINDOWS(NWINDOWS)) u_map_rs1 (
        .lreg (rs1),
        .cwp  (r_cwp),
        .preg (w_rs1_idx)
    );

    window_index_map #(.NWINDOWS(NWINDOWS)) u_map_rs2 (
        .lreg (rs2),
        .cwp  (r_cwp),
        .preg (w_rs2_idx)
    );

    window_index_map #(.NWINDOWS(NWINDOWS)) u_map_rd (
        .lreg (rd),
        .cwp  (w_rd_cwp),
        .preg (w_rd_idx)
    );

    // No bypass: reads always show the value stored before the edge.
    assign rs1_data = (rs1 == 5'd0) ? '0 : r_regs[w_rs1_idx];
    assign rs2_data = (rs2 == 5'd0) ? '0 : r_regs[w_rs2_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cwp      <= '0;
            r_wim      <= '0;
            r_trap_ovf <= 1'b0;
            r_trap_unf <= 1'b0;
            for (int i = 0; i < c_NPHYS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_cwp      <= w_cwp_next;
            r_trap_ovf <= w_ovf;
            r_trap_unf <= w_unf;
            if (wr_wim) begin
                r_wim <= wim_in;
            end
            if (w_wr_go) begin
                r_regs[w_rd_idx] <= wr_data;
            end
        end
    end

    assign cwp      = r_cwp;
    assign wim      = r_wim;
    assign trap_ovf = r_trap_ovf;
    assign trap_unf = r_trap_unf;

endmodule
`default_nettype wire

// File: tb/tb_register_window_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_window_file
//  Description : Scoreboard bench for register_window_file. Stimulus pushes
//                expected outputs from a behavioural model into a queue; a
//                monitor on the falling edge pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_register_window_file;

    localparam int NW = 4;
    localparam int W  = 32;
    localparam int CW = 2;
    localparam int NP = 8 + 16 * NW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    rs1, rs2, rd;
    logic [W-1:0]  rs1_data, rs2_data, wr_data;
    logic          wr_en, save, restore, wr_wim, wr_cwp;
    logic [NW-1:0] wim_in, wim;
    logic [CW-1:0] cwp_in, cwp;
    logic          trap_ovf, trap_unf;

    always #5 clk = ~clk;

    register_window_file #(.NWINDOWS(NW), .WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd       (rd),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .save     (save),
        .restore  (restore),
        .wr_wim   (wr_wim),
        .wim_in   (wim_in),
        .wr_cwp   (wr_cwp),
        .cwp_in   (cwp_in),
        .cwp      (cwp),
        .wim      (wim),
        .trap_ovf (trap_ovf),
        .trap_unf (trap_unf)
    );

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        int           cwp;
        int           wim;
        bit           ovf;
        bit           unf;
        longint       pin_r1;
        int           pin_cwp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: logical view over a flat physical array.
    logic [W-1:0] m_regs [NP];
    int           m_cwp;
    int           m_wim;
    bit           m_ovf, m_unf;

    function automatic int phys(input int r, input int w);
        if (r < 8) return r;
        return 8 + ((w * 16 + r - 8) % (16 * NW));
    endfunction

    function automatic logic [W-1:0] mread(input int r);
        if (r == 0) return '0;
        return m_regs[phys(r, m_cwp)];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_regs[i] = '0;
        m_cwp = 0;
        m_wim = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        wr_en = 0; rd = 0; wr_data = '0; save = 0; restore = 0;
        wr_wim = 0; wim_in = '0; wr_cwp = 0; cwp_in = '0;
    endtask

    // One clock of stimulus. pin_r1/pin_cwp >= 0 add fixed expectations.
    // abort asserts reset_n in the second half of the cycle so the edge
    // carrying the write happens while reset is held.
    task automatic do_cycle(input bit we, input int rdv, input logic [W-1:0] d,
                            input bit sv, input bit rs, input bit ww, input int wimv,
                            input bit wc, input int cwpv, input int r1, input int r2,
                            input longint pin_r1, input int pin_cwp, input bit abort);
        exp_t e;
        int   n, wcwp, ncwp;
        bit   ovf, unf;
        @(posedge clk); #1;
        wr_en = we; rd = rdv[4:0]; wr_data = d; save = sv; restore = rs;
        wr_wim = ww; wim_in = wimv[NW-1:0]; wr_cwp = wc; cwp_in = cwpv[CW-1:0];
        rs1 = r1[4:0]; rs2 = r2[4:0];
        e.r1 = mread(r1);
        e.r2 = mread(r2);
        e.cwp = m_cwp;
        e.wim = m_wim;
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.pin_r1 = pin_r1;
        e.pin_cwp = pin_cwp;
        q.push_back(e);
        if (abort) begin
            @(negedge clk); #1;
            reset_n = 0;
            model_reset();
            @(posedge clk); #1;
            drive_idle();
            reset_n = 1;
            return;
        end
        ovf = 0; unf = 0; wcwp = m_cwp; ncwp = m_cwp;
        if (wc) begin
            ncwp = cwpv % NW;
        end else if (sv && rs) begin
            ncwp = m_cwp;
        end else if (sv) begin
            n = (m_cwp + NW - 1) % NW;
            if (((m_wim >> n) & 1) != 0) ovf = 1;
            else begin ncwp = n; wcwp = n; end
        end else if (rs) begin
            n = (m_cwp + 1) % NW;
            if (((m_wim >> n) & 1) != 0) unf = 1;
            else begin ncwp = n; wcwp = n; end
        end
        if (we && rdv != 0 && !ovf && !unf) m_regs[phys(rdv, wcwp)] = d;
        if (ww) m_wim = wimv % (1 << NW);
        m_cwp = ncwp;
        m_ovf = ovf;
        m_unf = unf;
    endtask

    // Monitor: every falling edge with a pending expectation is checked.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("rs1_data", rs1_data, e.r1);
            cmp("rs2_data", rs2_data, e.r2);
            cmp("cwp", cwp, e.cwp);
            cmp("wim", wim, e.wim);
            cmp("trap_ovf", trap_ovf, e.ovf);
            cmp("trap_unf", trap_unf, e.unf);
            cmp("trap_exclusive", trap_ovf & trap_unf, 0);
            if (e.pin_r1 >= 0) cmp("rs1_fixed", rs1_data, e.pin_r1);
            if (e.pin_cwp >= 0) cmp("cwp_fixed", cwp, e.pin_cwp);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we, rdv, r1, r2, wimv;
        drive_idle();
        rs1 = 0; rs2 = 0;
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        //        we rd data           sv rs ww wim wc cw r1  r2  pin         pcwp ab
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 5,  0,  0,          0,  0); // reset state
        do_cycle(1, 0,  32'hFFFF_FFFF, 0, 0, 0, 0,  0, 0, 0,  0,  -1,         -1, 0); // write r0
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 0,  3,  0,          0,  0); // r0 reads 0
        do_cycle(1, 3,  32'h1234,      0, 0, 0, 0,  0, 0, 3,  0,  -1,         -1, 0);
        do_cycle(0, 0,  32'h0,         1, 0, 0, 0,  0, 0, 3,  0,  32'h1234,   0,  0); // SAVE
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 3,  0,  32'h1234,   3,  0); // global kept
        do_cycle(0, 0,  32'h0,         0, 1, 0, 0,  0, 0, 3,  0,  -1,         3,  0); // RESTORE
        do_cycle(1, 8,  32'hA5A5,      0, 0, 0, 0,  0, 0, 8,  0,  0,          0,  0);
        do_cycle(0, 0,  32'h0,         1, 0, 0, 0,  0, 0, 8,  0,  32'hA5A5,   0,  0); // SAVE
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 24, 8,  32'hA5A5,   3,  0); // in aliases out
        do_cycle(0, 0,  32'h0,         0, 1, 0, 0,  0, 0, 24, 0,  32'hA5A5,   3,  0); // RESTORE
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 8,  0,  32'hA5A5,   0,  0);
        do_cycle(0, 0,  32'h0,         0, 0, 1, 8,  0, 0, 9,  0,  0,          0,  0); // wim=1000
        do_cycle(1, 9,  32'h9999,      1, 0, 0, 0,  0, 0, 9,  0,  0,          0,  0); // overflow
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 9,  0,  0,          0,  0); // trap cycle
        do_cycle(0, 0,  32'h0,         0, 0, 1, 0,  0, 0, 9,  0,  0,          0,  0); // wim=0
        do_cycle(1, 9,  32'h9999,      1, 0, 0, 0,  0, 0, 9,  0,  0,          0,  0); // SAVE ok
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 9,  25, 32'h9999,   3,  0);
        do_cycle(0, 0,  32'h0,         0, 0, 1, 1,  0, 0, 9,  0,  32'h9999,   3,  0); // wim=0001
        do_cycle(0, 0,  32'h0,         0, 1, 0, 0,  0, 0, 9,  0,  32'h9999,   3,  0); // underflow
        do_cycle(0, 0,  32'h0,         0, 0, 1, 0,  0, 0, 9,  0,  32'h9999,   3,  0);
        do_cycle(0, 0,  32'h0,         1, 1, 0, 0,  0, 0, 9,  0,  32'h9999,   3,  0); // save+restore
        do_cycle(0, 0,  32'h0,         1, 0, 0, 0,  1, 2, 9,  0,  32'h9999,   3,  0); // wr_cwp+save
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 10, 0,  0,          2,  0);
        do_cycle(1, 10, 32'hDEAD,      0, 0, 0, 0,  0, 0, 10, 0,  0,          2,  1); // reset mid-write
        do_cycle(0, 0,  32'h0,         0, 0, 0, 0,  0, 0, 10, 9,  0,          0,  0);

        for (int k = 0; k < 1500; k++) begin
            we   = $urandom_range(0, 1);
            rdv  = $urandom_range(0, 31);
            r1   = ($urandom_range(0, 3) == 0) ? rdv : $urandom_range(0, 31);
            r2   = $urandom_range(0, 31);
            wimv = $urandom_range(0, 15) & $urandom_range(0, 15);
            do_cycle(we[0], rdv, $urandom,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 11) == 0, wimv,
                     $urandom_range(0, 23) == 0, $urandom_range(0, NW - 1),
                     r1, r2, -1, -1, 0);
        end

        @(posedge clk); #1;
        drive_idle();
        repeat (2) @(posedge clk);
        cmp("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
